// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, port-select constants and default timeout
// for the instruction/data memory arbiter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_e;
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;
   localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts memory wait cycles, holding once it reaches MAX
// so done stays asserted until the next clear.
module mem_timeout_counter #(
   parameter int MAX = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic done_o
);
   localparam int W = $clog2(MAX + 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign done_o = cnt_q == W'(MAX);
   always_comb cnt_d = clr_i ? '0 : (en_i && !done_o) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single memory port with
// alternating priority on contention and a mem_ready timeout.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic            i_ack,
   output logic [XLEN-1:0] i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   input  logic [2:0]      d_mode,
   output logic            d_ack,
   output logic [XLEN-1:0] d_rdata,
   output logic            err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [2:0]      mem_mode,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata
);
   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [2:0]        mem_mode_q, mem_mode_d;
   logic [XLEN-1:0]   rd_q, rd_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic              err_p_q, err_p_d, err_q, err_d;
   logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
   logic              grant_d, clr, en, done;

   mem_timeout_counter #(.MAX(TIMEOUT)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (clr),
      .en_i   (en),
      .done_o (done)
   );

   // data wins when alone or when the instruction port was served last
   assign grant_d = d_req && (!i_req || last_q == PORT_I);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_mode_d  = mem_mode_q;
      rd_d        = rd_q;
      err_p_d     = err_p_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      err_d       = 1'b0;
      clr         = 1'b0;
      en          = 1'b0;
      case (state_q)
         IDLE: if (i_req || d_req) begin
            clr         = 1'b1;
            last_d      = grant_d ? PORT_D : PORT_I;
            state_d     = grant_d ? D_BUSY : I_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = grant_d && d_we;
            mem_addr_d  = grant_d ? d_addr : i_addr;
            mem_wdata_d = grant_d ? d_wdata : '0;
            mem_mode_d  = grant_d ? d_mode : 3'b000;
         end
         I_BUSY, D_BUSY: if (mem_ready || done) begin
            rd_d      = (mem_ready && !mem_we_q) ? mem_rdata : '0;
            err_p_d   = !mem_ready;
            mem_req_d = 1'b0;
            state_d   = RESP;
         end else begin
            en = 1'b1;
         end
         RESP: begin
            state_d   = IDLE;
            err_d     = err_p_q;
            i_ack_d   = last_q == PORT_I;
            d_ack_d   = last_q == PORT_D;
            i_rdata_d = last_q == PORT_I ? rd_q : i_rdata_q;
            d_rdata_d = last_q == PORT_D ? rd_q : d_rdata_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= PORT_I;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_mode_q  <= '0;
         rd_q        <= '0;
         err_p_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_mode_q  <= mem_mode_d;
         rd_q        <= rd_d;
         err_p_q     <= err_p_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         err_q       <= err_d;
      end
   end

   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_mode  = mem_mode_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with TIMEOUT=4.
module tb_mem_arbiter;
   localparam int TO = 4;
   localparam logic [31:0] JUNK = 32'hBAD0BAD0;
   logic clk = 1'b0, reset = 1'b1;
   logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = JUNK;
   logic [2:0] d_mode = '0;
   logic i_ack, d_ack, err, mem_req, mem_we;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [2:0] mem_mode;
   logic [31:0] exp_i_rd = '0, exp_d_rd = '0;
   int total = 0, bad = 0;

   mem_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mode(mem_mode), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Full transaction from request to the cycle after ack; ready_at is the
   // busy cycle (1-based) in which mem_ready pulses, 0 for never.
   task automatic access(input string tag, input logic isd, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] mode, input int ready_at,
                         input logic [31:0] rd, input logic exp_err);
      int n, exp_n;
      logic [31:0] exp_rd;
      if (isd) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_mode = mode;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      tick;
      n = 0;
      while (mem_req && n < 20) begin
         n++;
         chk({tag, " mem_we"}, 32'(mem_we), 32'(isd && we));
         chk({tag, " mem_addr"}, mem_addr, addr);
         chk({tag, " mem_wdata"}, mem_wdata, isd ? wdata : 32'h0);
         chk({tag, " mem_mode"}, 32'(mem_mode), isd ? 32'(mode) : 32'h0);
         mem_ready = n == ready_at;
         mem_rdata = n == ready_at ? rd : JUNK;
         tick;
         mem_ready = 1'b0;
         mem_rdata = JUNK;
      end
      exp_n = (ready_at > 0 && ready_at <= TO + 1) ? ready_at : TO + 1;
      chk({tag, " busy_cycles"}, 32'(n), 32'(exp_n));
      chk({tag, " early_ack"}, 32'({i_ack, d_ack}), 32'h0);
      tick;
      exp_rd = (exp_err || (isd && we)) ? 32'h0 : rd;
      if (isd) exp_d_rd = exp_rd; else exp_i_rd = exp_rd;
      chk({tag, " i_ack"}, 32'(i_ack), 32'(!isd));
      chk({tag, " d_ack"}, 32'(d_ack), 32'(isd));
      chk({tag, " err"}, 32'(err), 32'(exp_err));
      chk({tag, " i_rdata"}, i_rdata, exp_i_rd);
      chk({tag, " d_rdata"}, d_rdata, exp_d_rd);
      i_req = 1'b0; d_req = 1'b0;
      tick;
      chk({tag, " ack_gone"}, 32'({i_ack, d_ack, err}), 32'h0);
      chk({tag, " i_hold"}, i_rdata, exp_i_rd);
      chk({tag, " d_hold"}, d_rdata, exp_d_rd);
   endtask

   initial begin
      tick; tick;
      chk("rst acks", 32'({i_ack, d_ack, err, mem_req, mem_we}), 32'h0);
      chk("rst i_rdata", i_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst mem_mode", 32'(mem_mode), 32'h0);
      reset = 1'b0;
      tick;
      // contention straight out of reset: data first, then fetch
      i_req = 1'b1; i_addr = 32'h0000_0040;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_mode = 3'b010;
      tick;
      chk("cont d mem_addr", mem_addr, 32'h0000_3000);
      chk("cont d mem_mode", 32'(mem_mode), 32'h2);
      mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
      tick;
      mem_ready = 1'b0; mem_rdata = JUNK;
      tick;
      chk("cont d_ack", 32'({i_ack, d_ack}), 32'h1);
      chk("cont d_rdata", d_rdata, 32'h1111_2222);
      exp_d_rd = 32'h1111_2222;
      d_req = 1'b0;
      tick;
      chk("cont i grant", 32'({i_ack, d_ack, mem_req}), 32'h1);
      chk("cont i mem_addr", mem_addr, 32'h0000_0040);
      mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
      tick;
      mem_ready = 1'b0; mem_rdata = JUNK;
      tick;
      chk("cont i_ack", 32'({i_ack, d_ack}), 32'h2);
      chk("cont i_rdata", i_rdata, 32'h3333_4444);
      exp_i_rd = 32'h3333_4444;
      i_req = 1'b0;
      tick;
      // fetch with first-cycle ready: ack visible after the third edge
      access("fetch", 1'b0, 1'b0, 32'h100, 32'h0, 3'b000, 1, 32'h0050_0093, 1'b0);
      access("store", 1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 3'b000, 5, JUNK, 1'b0);
      access("load", 1'b1, 1'b0, 32'h2004, 32'h0, 3'b100, 3, 32'h8765_4321, 1'b0);
      access("timeout", 1'b1, 1'b0, 32'h2008, 32'h0, 3'b010, 0, JUNK, 1'b1);
      access("boundary", 1'b0, 1'b0, 32'h104, 32'h0, 3'b000, TO + 1, 32'hCAFE_F00D, 1'b0);
      // stray mem_ready while idle must be ignored
      mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
      tick;
      mem_ready = 1'b0; mem_rdata = JUNK;
      tick; tick;
      chk("stray ack", 32'({i_ack, d_ack, err, mem_req}), 32'h0);
      chk("stray i_rdata", i_rdata, exp_i_rd);
      // reset mid data access abandons it silently
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2100; d_mode = 3'b010;
      tick;
      chk("midrst busy", 32'(mem_req), 32'h1);
      reset = 1'b1;
      tick;
      reset = 1'b0; d_req = 1'b0;
      chk("midrst mem_req", 32'({mem_req, i_ack, d_ack}), 32'h0);
      tick; tick;
      chk("midrst no ack", 32'({mem_req, i_ack, d_ack}), 32'h0);
      exp_i_rd = '0; exp_d_rd = '0;
      access("post_rst", 1'b0, 1'b0, 32'h200, 32'h0, 3'b000, 2, 32'h0BAD_CAFE, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
